serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial front end for the serial pattern-detector stages. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `sout`, which drives the detector's `x` input directly. Back-to-back words stream with no idle bit between them. `sout` is held at 0 when the block has no data to send, so an idle line is never seen as a run of 1s.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `din`  input  WIDTH: parallel word; sampled only on a handshake.
- `din_valid`  input  1: `din` holds a word to send.
- `din_ready`  output  1: the block can accept a word this cycle.
- `sout`  output  1: serial bit stream; feeds the detector `x`.
- `sout_valid`  output  1: `sout` carries a data bit this cycle.
- `word_done`  output  1: 1-cycle pulse during the last bit of a word.
- `busy`  output  1: a word is being shifted; equals `sout_valid`.

## Operation
- State machine:
  - Two states, S_IDLE and S_SHIFT.
  - Registers: `shift_reg` (WIDTH bits) and `bit_cnt` ($clog2(WIDTH) bits).
- Handshake:
  - A transfer occurs on a rising edge where `din_valid && din_ready`.
  - `din_ready = (state==S_IDLE) || (state==S_SHIFT && bit_cnt==WIDTH-1)`. It is combinational from registers only and has no path from `din_valid`.
  - `din` and `din_valid` are ignored whenever no transfer occurs.
- S_IDLE:
  - `sout` = 0 and `sout_valid` = 0.
  - On a transfer: load `din` into `shift_reg`, clear `bit_cnt` to 0, and go to S_SHIFT.
- S_SHIFT:
  - `sout` = `shift_reg[WIDTH-1]` when MSB_FIRST=1, or `shift_reg[0]` when MSB_FIRST=0.
  - `sout_valid` = 1.
  - On each edge with `bit_cnt < WIDTH-1`: shift by one (left for MSB-first, right for LSB-first), zero-fill, and increment `bit_cnt`.
  - On the edge with `bit_cnt == WIDTH-1`:
    - With a transfer: reload `din`, clear `bit_cnt` to 0, and stay in S_SHIFT. This gives a gapless stream.
    - Without a transfer: go to S_IDLE and clear `shift_reg` to 0.
- `word_done` = `sout_valid && bit_cnt==WIDTH-1`. It is asserted exactly once per word.
- `bit_cnt` never exceeds WIDTH-1. For non-power-of-2 WIDTH there is no wrap beyond WIDTH-1.
- Unreachable state encodings return to S_IDLE with `sout` = 0.

## Timing
- Reset values (applied asynchronously, immediately on `reset_n` low):
  - state = S_IDLE, `shift_reg` = 0, `bit_cnt` = 0.
  - `sout` = 0, `sout_valid` = 0, `word_done` = 0, `busy` = 0.
  - `din_ready` = 1. No transfer is taken while `reset_n` is low.
- Latency: a word accepted at edge k puts its first bit on `sout` for the cycle after edge k. Its last bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one bit per cycle, and one word per WIDTH cycles when `din_valid` is held high.
- Simultaneous events: a reload on the last bit takes priority over returning to S_IDLE.
- Reset mid-word: the partial word is discarded with no completion pulse, and no bits of it appear after reset release.
- All outputs are glitch-free functions of registers.

## Structure
- Shared package `serial_pkg` holds:
  - the state encodings S_IDLE=1'b0 and S_SHIFT=1'b1;
  - the default word width constant, 8.
- Single module with no sub-modules. The counter and shifter are too small to split out.
- Top-level connection: `sout` → detector `x`. `clk` and `reset_n` are shared with the detector.

## Test plan
- Reset, then `din_valid` held low for 20 cycles → `sout`=0, `sout_valid`=0, `din_ready`=1 throughout.
- MSB_FIRST=1, send 8'hD0 → `sout` = 1,1,0,1,0,0,0,0 starting the cycle after the handshake. `word_done` is high only on the 8th bit. The downstream detector pulses `y`=1 during bit 4.
- Back-to-back 8'hA5 then 8'h3C with `din_valid` held high → 16 consecutive valid bits 1010_0101_0011_1100 with no gap. `din_ready` is high only on bit 8 of the first word. `word_done` pulses twice.
- MSB_FIRST=0, send 8'h0B → `sout` = 1,1,0,1,0,0,0,0.
- Send 8'hFF and assert `reset_n` low after 3 bits → `sout` and `sout_valid` go to 0 immediately. After release, send 8'h80 → `sout` = 1,0,0,0,0,0,0,0 with no leftover 1s.
- WIDTH=5, send 5'b10110 → 5 bits 1,0,1,1,0. `bit_cnt` peaks at 4, then the block returns to S_IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial pattern-detector front end.
//   state_t        : feeder state encoding (S_IDLE / S_SHIFT)
//   DEFAULT_WIDTH  : default parallel word length in bits
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
// Parallel-to-serial front end for the serial pattern detector. Words arrive on
// a valid/ready handshake and leave one bit per clock on sout, which drives the
// detector x input. Consecutive words stream with no idle bit in between, and
// sout is forced low whenever no data bit is being sent.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   din         in   parallel word, sampled only on a handshake
//   din_valid   in   din holds a word to send
//   din_ready   out  a word can be accepted this cycle
//   sout        out  serial bit stream (detector x)
//   sout_valid  out  sout carries a data bit this cycle
//   word_done   out  one-cycle pulse during the last bit of each word
//   busy        out  a word is being shifted (same as sout_valid)
// -----------------------------------------------------------------------------
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift_reg;
    logic [CNT_W-1:0] r_bit_cnt;

    logic w_shifting;
    logic w_last_bit;
    logic w_xfer;
    logic w_out_bit;

    // Move the next bit into the output position and zero-fill, so a word
    // that drains never leaves stale 1s behind it.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign w_shifting = (r_state == S_SHIFT);
    assign w_last_bit = w_shifting && (r_bit_cnt == LAST_BIT);
    assign w_out_bit  = MSB_FIRST ? r_shift_reg[WIDTH-1] : r_shift_reg[0];

    // Ready depends on registers only: idle, or showing the final bit so the
    // next word can follow without a gap.
    assign din_ready  = (r_state == S_IDLE) || w_last_bit;
    assign w_xfer     = din_valid && din_ready;

    // Gate with the state so an idle line is always 0.
    assign sout       = w_shifting && w_out_bit;
    assign sout_valid = w_shifting;
    assign busy       = w_shifting;
    assign word_done  = w_last_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_shift_reg <= din;
                        r_bit_cnt   <= '0;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt < LAST_BIT) begin
                        r_shift_reg <= shift_one(r_shift_reg);
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                    end else if (w_xfer) begin
                        // Reload on the last bit wins over going idle.
                        r_shift_reg <= din;
                        r_bit_cnt   <= '0;
                        r_state     <= S_SHIFT;
                    end else begin
                        r_shift_reg <= '0;
                        r_bit_cnt   <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_shift_reg <= '0;
                    r_bit_cnt   <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule : serial_bit_feeder

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
// Three feeder instances (8-bit MSB-first, 8-bit LSB-first, 5-bit MSB-first)
// run side by side against a bit-queue reference model: each accepted word
// appends its bits in send order, each clock consumes one bit.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

    localparam int NI = 3;
    localparam int WI [NI] = '{8, 8, 5};
    localparam bit MI [NI] = '{1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] din [NI];
    logic       dv  [NI];
    logic       rdy [NI];
    logic       so  [NI];
    logic       sv  [NI];
    logic       wd  [NI];
    logic       bsy [NI];

    int n_checks = 0;
    int n_fail   = 0;

    bit          q   [NI][$];
    logic [31:0] cap [NI];
    int          wdc [NI];

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .reset_n(reset_n), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]),
        .word_done(wd[0]), .busy(bsy[0]));

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .reset_n(reset_n), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]),
        .word_done(wd[1]), .busy(bsy[1]));

    serial_bit_feeder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_msb5 (
        .clk(clk), .reset_n(reset_n), .din(din[2][4:0]), .din_valid(dv[2]),
        .din_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]),
        .word_done(wd[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            logic e_v, e_b, e_d, e_r;
            e_v = (q[k].size() > 0);
            e_b = e_v ? q[k][0] : 1'b0;
            e_d = (q[k].size() == 1);
            e_r = (q[k].size() <= 1);
            check($sformatf("sout_valid%0d", k), 32'(sv[k]),  32'(e_v));
            check($sformatf("sout%0d", k),       32'(so[k]),  32'(e_b));
            check($sformatf("word_done%0d", k),  32'(wd[k]),  32'(e_d));
            check($sformatf("din_ready%0d", k),  32'(rdy[k]), 32'(e_r));
            check($sformatf("busy%0d", k),       32'(bsy[k]), 32'(e_v));
            if (sv[k] === 1'b1) cap[k] = {cap[k][30:0], so[k]};
            if (wd[k] === 1'b1) wdc[k]++;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) q[k].delete();
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!reset_n) begin
            clear_model();
        end else begin
            for (int k = 0; k < NI; k++) begin
                bit take;
                take = dv[k] && (q[k].size() <= 1);
                if (q[k].size() > 0) void'(q[k].pop_front());
                if (take)
                    for (int i = 0; i < WI[k]; i++)
                        q[k].push_back(MI[k] ? din[k][WI[k]-1-i] : din[k][i]);
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        for (int k = 0; k < NI; k++) begin
            cap[k] = '0;
            wdc[k] = 0;
        end
    endtask

    task automatic send(input int k, input logic [7:0] w);
        din[k] = w;
        dv[k]  = 1'b1;
        tick();
        dv[k]  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            din[k] = 8'h00;
            dv[k]  = 1'b0;
        end
        clear_obs();

        // Reset held with din_valid high: nothing may be accepted.
        dv[0] = 1'b1;
        din[0] = 8'hFF;
        ticks(3);
        dv[0] = 1'b0;
        reset_n = 1'b1;

        // Idle line.
        ticks(20);

        // 8'hD0 MSB-first.
        clear_obs();
        send(0, 8'hD0);
        ticks(9);
        check("d0_bits", cap[0], 32'h0000_00D0);
        check("d0_done_cnt", 32'(wdc[0]), 32'd1);

        // Back-to-back A5, 3C.
        clear_obs();
        din[0] = 8'hA5;
        dv[0]  = 1'b1;
        tick();
        din[0] = 8'h3C;
        ticks(8);
        dv[0]  = 1'b0;
        ticks(9);
        check("b2b_bits", cap[0], 32'h0000_A53C);
        check("b2b_done_cnt", 32'(wdc[0]), 32'd2);

        // 8'h0B LSB-first.
        clear_obs();
        send(1, 8'h0B);
        ticks(9);
        check("lsb_0b_bits", cap[1], 32'h0000_00D0);

        // Reset after three bits of 8'hFF.
        clear_obs();
        send(0, 8'hFF);
        ticks(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_sout", 32'(so[0]), 32'd0);
        check("rst_sout_valid", 32'(sv[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_done", 32'(wd[0]), 32'd0);
        clear_model();
        ticks(2);
        reset_n = 1'b1;
        check("ff_partial_bits", cap[0], 32'h0000_0007);
        check("ff_no_done", 32'(wdc[0]), 32'd0);
        clear_obs();
        send(0, 8'h80);
        ticks(9);
        check("after_rst_80", cap[0], 32'h0000_0080);

        // 5-bit word.
        clear_obs();
        send(2, 8'h16);
        ticks(7);
        check("w5_bits", cap[2], 32'h0000_0016);
        check("w5_done_cnt", 32'(wdc[2]), 32'd1);

        // Randomised traffic on all three instances.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NI; k++) begin
                dv[k]  = ($urandom_range(0, 3) != 0);
                din[k] = 8'($urandom());
            end
            if (n == 1500) begin
                #2;
                reset_n = 1'b0;
                #1;
                clear_model();
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        for (int k = 0; k < NI; k++) dv[k] = 1'b0;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_bit_feeder
